// File: rtl/seg7_scan_display.sv
// N-digit multiplexed seven-segment driver: hex decode, per-digit dp, PWM dimming, frame-committed updates.
// Latency: seg/dp/dig_sel registered 1 clk behind the scan state; load_ack 1 clk after the committing boundary.
// Backpressure: none; latest load overwrites pending. Optional SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_display #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int PWM_BITS   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset_in,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   output logic                  load_ack,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_strb
);

   localparam int   DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic POL   = (ACTIVE_LOW != 0);

   logic [DIV_W-1:0]    div;
   logic [IDX_W-1:0]    idx;
   logic [PWM_BITS-1:0] pwm;
   logic [4*DIGITS-1:0] disp_val, pend_val;
   logic [DIGITS-1:0]   disp_dp, pend_dp;
   logic                pend;
   logic                div_wrap, idx_wrap, boundary;

   logic [3:0]          nib;
   logic                nib_dp, nib_blank, lit;
   logic [6:0]          seg_hi;
   logic [DIGITS-1:0]   sel_hi;

   assign div_wrap   = (div == DIV_W'(SCAN_DIV - 1));
   assign idx_wrap   = (idx == IDX_W'(DIGITS - 1));
   assign boundary   = div_wrap && idx_wrap;
   assign frame_strb = boundary;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'h3F;
         4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;
         4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;
         4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;
         4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;
         4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;
         4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;
         4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;
         default: hex_decode = 7'h71;
      endcase
   endfunction

`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS-1:0] blank;
   logic              lz_run;

   // A digit blanks only while every digit from the top down to it is zero.
   always_comb begin
      lz_run = 1'b1;
      blank  = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         lz_run   = lz_run && (disp_val[i*4 +: 4] == 4'h0);
         blank[i] = lz_run;
      end
   end
`endif

   always_comb begin
      nib       = 4'h0;
      nib_dp    = 1'b0;
      nib_blank = 1'b0;
      sel_hi    = '0;
      lit       = (pwm < brightness);
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nib       = disp_val[i*4 +: 4];
            nib_dp    = disp_dp[i];
`ifdef SEG7_LZ_BLANK_EN
            nib_blank = blank[i];
`endif
            sel_hi[i] = lit;
         end
      end
      seg_hi = nib_blank ? 7'h00 : hex_decode(nib);
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         div      <= '0;
         idx      <= '0;
         pwm      <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
         pend_val <= '0;
         pend_dp  <= '0;
         pend     <= 1'b0;
         load_ack <= 1'b0;
         seg      <= {7{POL}};
         dp       <= POL;
         dig_sel  <= {DIGITS{POL}};
      end else begin
         pwm <= pwm + 1'b1;
         div <= div_wrap ? '0 : div + 1'b1;
         if (div_wrap)
            idx <= idx_wrap ? '0 : idx + 1'b1;

         // Commit reads the old pending copy, so a load in the boundary cycle waits one frame.
         load_ack <= boundary && pend;
         if (boundary && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         if (load) begin
            pend_val <= value_in;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
         end else if (boundary) begin
            pend     <= 1'b0;
         end

         seg     <= seg_hi ^ {7{POL}};
         dp      <= nib_dp ^ POL;
         dig_sel <= sel_hi ^ {DIGITS{POL}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display at DIGITS=4, SCAN_DIV=4, PWM_BITS=2, active-low outputs.
module tb_seg7_scan_display;

   logic        clk = 1'b0;
   logic        reset_in;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        load_ack;
   logic [1:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic        frame_strb;

   int checks = 0;
   int errors = 0;
   int ack_seen = 0;

`ifdef SEG7_LZ_BLANK_EN
   localparam logic [6:0] ZSEG = 7'h7F;
`else
   localparam logic [6:0] ZSEG = 7'h40;
`endif

   typedef struct packed {
      logic [15:0] val;
      logic [3:0]  dpv;
      logic [3:0]  dpn;
      logic [27:0] segs;   // expected {d3,d2,d1,d0} active-low
   } vec_t;

   always #5 clk = ~clk;

   always @(posedge clk) if (load_ack === 1'b1) ack_seen++;

   seg7_scan_display #(
      .DIGITS(4), .SCAN_DIV(4), .PWM_BITS(2), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset_in(reset_in), .value_in(value_in), .dp_in(dp_in),
      .load(load), .load_ack(load_ack), .brightness(brightness),
      .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_strb(frame_strb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_strb(input string name);
      int n = 0;
      while (frame_strb !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (frame_strb !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: no frame_strb within 40 clk", name);
      end
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] d);
      value_in = v;
      dp_in    = d;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   // Called in the cycle after a boundary; sample k shows scan position k.
   task automatic scan_check(input string name, input logic [27:0] segs, input logic [3:0] dpn,
                             output int acks);
      acks = 0;
      for (int k = 0; k < 16; k++) begin
         int         ix, pw;
         logic [3:0] sel;
         logic [11:0] exp;
         @(negedge clk);
         ix  = k / 4;
         pw  = k % 4;
         sel = (pw < int'(brightness)) ? ~(4'b0001 << ix) : 4'hF;
         exp = {segs[ix*7 +: 7], dpn[ix], sel};
         check($sformatf("%s k=%0d", name, k), {20'd0, seg, dp, dig_sel}, {20'd0, exp});
         if (load_ack === 1'b1) acks++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [5];
      int   acks, nstrb, first, base;

      tbl[0] = '{16'h12AF, 4'b0100, 4'b1011, {7'h79, 7'h24, 7'h08, 7'h0E}};
      tbl[1] = '{16'h4567, 4'b0000, 4'b1111, {7'h19, 7'h12, 7'h02, 7'h78}};
      tbl[2] = '{16'hDCB9, 4'b1111, 4'b0000, {7'h21, 7'h46, 7'h03, 7'h10}};
      tbl[3] = '{16'h0E38, 4'b0001, 4'b1110, {ZSEG,  7'h06, 7'h30, 7'h00}};
      tbl[4] = '{16'h0050, 4'b0000, 4'b1111, {ZSEG,  ZSEG,  7'h12, 7'h40}};

      reset_in   = 1'b1;
      value_in   = '0;
      dp_in      = '0;
      load       = 1'b0;
      brightness = 2'd0;

      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("reset outputs", {19'd0, seg, dp, dig_sel, load_ack}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
      end
      reset_in = 1'b0;

      nstrb = 0;
      first = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) @(negedge clk);
         if (frame_strb === 1'b1) begin
            nstrb++;
            if (first == 0) first = c;
         end
      end
      check("first frame_strb cycle", first, 16);
      check("frame_strb count", nstrb, 1);

      brightness = 2'd3;
      for (int r = 0; r < 5; r++) begin
         load_val(tbl[r].val, tbl[r].dpv);
         wait_strb("commit");
         @(negedge clk);
         check($sformatf("load_ack rec%0d", r), load_ack, 1);
         scan_check($sformatf("scan rec%0d", r), tbl[r].segs, tbl[r].dpn, acks);
         check($sformatf("extra ack rec%0d", r), acks, 0);
      end

      // Two loads inside one frame: only the later value is committed, with one ack.
      base = ack_seen;
      load_val(16'h1111, 4'h0);
      @(negedge clk);
      @(negedge clk);
      load_val(16'h2222, 4'h0);
      wait_strb("reload");
      @(negedge clk);
      check("reload ack", load_ack, 1);
      scan_check("reload scan", {4{7'h24}}, 4'hF, acks);
      check("reload ack count", ack_seen - base, 1);

      // Load landing in the boundary cycle while another value is pending.
      load_val(16'h3333, 4'h0);
      wait_strb("boundary load");
      value_in = 16'h4444;
      dp_in    = 4'h0;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
      check("boundary first ack", load_ack, 1);
      scan_check("boundary 3333", {4{7'h30}}, 4'hF, acks);
      check("boundary acks in 3333 frame", acks, 1);
      check("boundary second ack", load_ack, 1);
      scan_check("boundary 4444", {4{7'h19}}, 4'hF, acks);
      check("boundary acks in 4444 frame", acks, 0);

      brightness = 2'd0;
      wait_strb("dark");
      @(negedge clk);
      scan_check("dark", {4{7'h19}}, 4'hF, acks);

      brightness = 2'd1;
      wait_strb("dim");
      @(negedge clk);
      scan_check("dim", {4{7'h19}}, 4'hF, acks);

      // Reset with a load pending: no ack, display cleared.
      brightness = 2'd3;
      load_val(16'h5555, 4'hF);
      @(negedge clk);
      reset_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_in = 1'b0;
      base = ack_seen;
      wait_strb("post reset");
      @(negedge clk);
      check("post reset no ack", load_ack, 0);
      scan_check("post reset", {ZSEG, ZSEG, ZSEG, 7'h40}, 4'hF, acks);
      check("post reset ack count", ack_seen - base, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
